frame_pad_loader: RTL and testbench

//  Write-side counterpart of the padded 3x3-window frame buffer.

---
 rtl/pixel_pkg.sv | 17 +
 rtl/raster_counter.sv | 37 +++
 rtl/frame_pad_loader.sv | 105 ++++++++++
 tb/tb_frame_pad_loader.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared pixel-buffer parameters and loader state encoding.
// Used by the frame loader and by the window reader.
package pixel_pkg;

  localparam int DATA_W = 8;
  localparam int IMG_W  = 64;
  localparam int IMG_H  = 64;
  localparam int PAD    = 1;
  localparam int AW     = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_t;

endpackage

// File: rtl/raster_counter.sv
// Row/column raster scan counter over a ROWS x COLS grid.
// Has a synchronous clear, an advance enable and a last-cell flag.
module raster_counter #(
  parameter int AW   = 7,
  parameter int ROWS = 66,
  parameter int COLS = 66
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [AW-1:0] row,
  output logic [AW-1:0] col,
  output logic          last
);

  localparam logic [AW-1:0] ROW_MAX = AW'(ROWS - 1);
  localparam logic [AW-1:0] COL_MAX = AW'(COLS - 1);

  assign last = (row == ROW_MAX) && (col == COL_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col == COL_MAX) begin
        col <= '0;
        // Wrapping past the final cell returns to the origin rather than overflowing.
        row <= last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_pad_loader.sv
// Fills a zero-padded frame buffer from a raster pixel stream, one write per cycle.
// Border cells are written with zero without consuming stream pixels.
module frame_pad_loader #(
  parameter int DATA_W = pixel_pkg::DATA_W,
  parameter int IMG_W  = pixel_pkg::IMG_W,
  parameter int IMG_H  = pixel_pkg::IMG_H,
  parameter int PAD    = pixel_pkg::PAD,
  parameter int AW     = pixel_pkg::AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pixel,
  output logic              mem_we,
  output logic [AW-1:0]     mem_row,
  output logic [AW-1:0]     mem_col,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              frame_done
);

  import pixel_pkg::*;

  localparam int ROWS = IMG_H + 2 * PAD;
  localparam int COLS = IMG_W + 2 * PAD;

  localparam logic [AW-1:0] TOP_END     = AW'(PAD);
  localparam logic [AW-1:0] BOT_START   = AW'(IMG_H + PAD);
  localparam logic [AW-1:0] LEFT_END    = AW'(PAD);
  localparam logic [AW-1:0] RIGHT_START = AW'(IMG_W + PAD);

  loader_state_t state, state_next;

  logic [AW-1:0] row, col;
  logic          last;
  logic          cnt_clr;
  logic          advance;
  logic          border;

  raster_counter #(
    .AW  (AW),
    .ROWS(ROWS),
    .COLS(COLS)
  ) u_scan (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .en   (advance),
    .row  (row),
    .col  (col),
    .last (last)
  );

  assign border = (row < TOP_END) || (row >= BOT_START) ||
                  (col < LEFT_END) || (col >= RIGHT_START);

  assign busy = (state != IDLE);

  // in_ready comes only from registered state and counters, never from in_valid.
  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    advance    = 1'b0;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          cnt_clr    = 1'b1;
        end
      end
      LOAD: begin
        in_ready = !border;
        advance  = border || in_valid;
        if (advance && last) state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem_we     <= 1'b0;
      mem_row    <= '0;
      mem_col    <= '0;
      mem_wdata  <= '0;
      frame_done <= 1'b0;
    end else begin
      state  <= state_next;
      mem_we <= advance;
      if (advance) begin
        mem_row   <= row;
        mem_col   <= col;
        mem_wdata <= border ? '0 : in_pixel;
      end
      // Registered from DONE so the pulse lands one cycle after the final write.
      frame_done <= (state == DONE);
    end
  end

endmodule

// File: tb/tb_frame_pad_loader.sv
// Directed bench for frame_pad_loader: full frames, stalls, reset abort, start filtering,
// and a small-geometry instance for the end-of-frame boundary.
module tb_frame_pad_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic       rst_n, start, in_valid;
  logic [7:0] in_pixel;
  logic       in_ready, mem_we, busy, frame_done;
  logic [6:0] mem_row, mem_col;
  logic [7:0] mem_wdata;

  logic       start_b, in_valid_b;
  logic [7:0] in_pixel_b;
  logic       in_ready_b, mem_we_b, busy_b, frame_done_b;
  logic [6:0] mem_row_b, mem_col_b;
  logic [7:0] mem_wdata_b;

  frame_pad_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .mem_we(mem_we), .mem_row(mem_row), .mem_col(mem_col),
    .mem_wdata(mem_wdata), .busy(busy), .frame_done(frame_done)
  );

  frame_pad_loader #(.DATA_W(8), .IMG_W(4), .IMG_H(3), .PAD(1), .AW(7)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_pixel(in_pixel_b), .mem_we(mem_we_b), .mem_row(mem_row_b), .mem_col(mem_col_b),
    .mem_wdata(mem_wdata_b), .busy(busy_b), .frame_done(frame_done_b)
  );

  int total = 0;
  int bad   = 0;

  // Monitor state for the full-size instance; cleared when epoch changes.
  int   epoch = 0, seen_epoch = 0;
  logic [7:0] img [66][66];
  int   wcnt [66][66];
  int   we_a, hs_a, stall_a, stall_we_a, noval_we_a, outside_a, rdy_idle_a, busy_a, done_a;
  int   done_cyc_a, last_we_a;
  bit   prev_busy, prev_stall, prev_noval;

  always @(negedge clk) begin
    if (epoch != seen_epoch) begin
      seen_epoch = epoch;
      for (int r = 0; r < 66; r++)
        for (int c = 0; c < 66; c++) begin
          wcnt[r][c] = 0;
          img[r][c]  = 8'hxx;
        end
      we_a = 0; hs_a = 0; stall_a = 0; stall_we_a = 0; noval_we_a = 0; outside_a = 0;
      rdy_idle_a = 0; busy_a = 0; done_a = 0; done_cyc_a = -1; last_we_a = -1;
    end
    if (rst_n) begin
      if (mem_we) begin
        we_a++;
        last_we_a = cyc;
        if (!prev_busy) outside_a++;
        if (prev_stall) stall_we_a++;
        if (prev_noval && (mem_row == 0 || mem_row == 65 || mem_col == 0 || mem_col == 65))
          noval_we_a++;
        if (mem_row < 66 && mem_col < 66) begin
          wcnt[mem_row][mem_col]++;
          img[mem_row][mem_col] = mem_wdata;
        end else begin
          outside_a++;
        end
      end
      if (in_ready && in_valid) hs_a++;
      if (in_ready && !in_valid) stall_a++;
      if (in_ready && !busy) rdy_idle_a++;
      if (busy) busy_a++;
      if (frame_done) begin
        done_a++;
        done_cyc_a = cyc;
      end
      prev_busy  = busy;
      prev_stall = in_ready && !in_valid;
      prev_noval = !in_valid;
    end else begin
      prev_busy = 1'b0; prev_stall = 1'b0; prev_noval = 1'b0;
    end
  end

  // Monitor for the small instance.
  logic [7:0] img_b [5][6];
  int   wcnt_b [5][6];
  int   we_b = 0, hs_b = 0, done_b = 0, done_cyc_b = -1, last_we_b = -1;
  int   last_row_b = -1, last_col_b = -1, last_data_b = -1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we_b) begin
        we_b++;
        last_we_b   = cyc;
        last_row_b  = int'(mem_row_b);
        last_col_b  = int'(mem_col_b);
        last_data_b = int'(mem_wdata_b);
        if (mem_row_b < 5 && mem_col_b < 6) begin
          wcnt_b[mem_row_b][mem_col_b]++;
          img_b[mem_row_b][mem_col_b] = mem_wdata_b;
        end
      end
      if (in_ready_b && in_valid_b) hs_b++;
      if (frame_done_b) begin
        done_b++;
        done_cyc_b = cyc;
      end
    end
  end

  // Reference image: zero border, interior pixel k = (r-1)*64 + (c-1) mod 256, each cell once.
  function automatic int image_errors();
    int errs = 0;
    for (int r = 0; r < 66; r++)
      for (int c = 0; c < 66; c++) begin
        logic [7:0] expv;
        if (r == 0 || r == 65 || c == 0 || c == 65) expv = 8'd0;
        else expv = 8'(((r - 1) * 64 + (c - 1)) % 256);
        if (wcnt[r][c] != 1 || img[r][c] !== expv) errs++;
      end
    return errs;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    epoch++;
    @(negedge clk);
    #1;
  endtask

  // Runs one frame on the full-size instance; returns the cycle start was presented.
  task automatic run_a(input bit gaps, input bit spam, output int t0, output bit timed_out);
    timed_out = 1'b0;
    tick();
    start    = 1'b1;
    in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
    in_pixel = hs_a[7:0];
    t0       = cyc;
    for (int n = 0; n < 20000; n++) begin
      tick();
      start    = spam ? busy : 1'b0;
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_pixel = hs_a[7:0];
      if (done_a != 0) return;
    end
    timed_out = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_pixel = 8'h00;
    start_b = 1'b0; in_valid_b = 1'b0; in_pixel_b = 8'h00;
    repeat (3) tick();
    total++;
    if ({in_ready, mem_we, busy, frame_done} !== 4'b0000 ||
        mem_row !== 7'd0 || mem_col !== 7'd0 || mem_wdata !== 8'd0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b we=%b busy=%b done=%b row=%0d col=%0d data=%0d want all 0",
               in_ready, mem_we, busy, frame_done, mem_row, mem_col, mem_wdata);
    end
    rst_n = 1'b1;
    tick();
    clear_stats();
  endtask

  task automatic test_full_frame();
    int t0; bit to; int errs;
    clear_stats();
    run_a(1'b0, 1'b0, t0, to);
    total++;
    if (to) begin bad++; $display("FAIL full_timeout: got no frame_done want frame_done"); end
    total++;
    if (we_a !== 4356) begin bad++; $display("FAIL full_writes: got %0d want 4356", we_a); end
    total++;
    if (hs_a !== 4096) begin bad++; $display("FAIL full_handshakes: got %0d want 4096", hs_a); end
    total++;
    if (done_a !== 1) begin bad++; $display("FAIL full_done_count: got %0d want 1", done_a); end
    total++;
    if (done_cyc_a !== t0 + 4358) begin
      bad++; $display("FAIL full_done_cycle: got %0d want %0d", done_cyc_a - t0, 4358);
    end
    total++;
    if (done_cyc_a !== last_we_a + 1) begin
      bad++; $display("FAIL full_done_after_last_we: got %0d want %0d", done_cyc_a, last_we_a + 1);
    end
    total++;
    if (busy_a !== 4357) begin bad++; $display("FAIL full_busy_cycles: got %0d want 4357", busy_a); end
    errs = image_errors();
    total++;
    if (errs !== 0) begin bad++; $display("FAIL full_image: got %0d bad cells want 0", errs); end
  endtask

  task automatic test_gaps();
    int t0; bit to; int errs;
    clear_stats();
    run_a(1'b1, 1'b0, t0, to);
    total++;
    if (to || done_a !== 1) begin bad++; $display("FAIL gaps_done: got %0d want 1", done_a); end
    errs = image_errors();
    total++;
    if (errs !== 0) begin bad++; $display("FAIL gaps_image: got %0d bad cells want 0", errs); end
    total++;
    if (stall_we_a !== 0) begin bad++; $display("FAIL gaps_we_after_stall: got %0d want 0", stall_we_a); end
    total++;
    if (busy_a !== 4357 + stall_a) begin
      bad++; $display("FAIL gaps_busy_cycles: got %0d want %0d", busy_a, 4357 + stall_a);
    end
    total++;
    if (stall_a == 0 || noval_we_a == 0) begin
      bad++; $display("FAIL gaps_coverage: got stalls=%0d border_noval=%0d want both >0", stall_a, noval_we_a);
    end
    total++;
    if (we_a !== 4356 || hs_a !== 4096) begin
      bad++; $display("FAIL gaps_counts: got we=%0d hs=%0d want 4356/4096", we_a, hs_a);
    end
  endtask

  task automatic test_mid_reset();
    int t0; bit to; int errs; bit hit;
    clear_stats();
    tick();
    start = 1'b1; in_valid = 1'b1; in_pixel = hs_a[7:0];
    hit = 1'b0;
    for (int n = 0; n < 2000 && !hit; n++) begin
      tick();
      start = 1'b0; in_pixel = hs_a[7:0];
      if (hs_a >= 1000) hit = 1'b1;
    end
    total++;
    if (!hit) begin bad++; $display("FAIL abort_reach: got hs=%0d want 1000", hs_a); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if ({in_ready, mem_we, busy, frame_done} !== 4'b0000 ||
        mem_row !== 7'd0 || mem_col !== 7'd0 || mem_wdata !== 8'd0) begin
      bad++;
      $display("FAIL abort_outputs: got rdy=%b we=%b busy=%b done=%b row=%0d col=%0d data=%0d want all 0",
               in_ready, mem_we, busy, frame_done, mem_row, mem_col, mem_wdata);
    end
    repeat (10) tick();
    total++;
    if (done_a !== 0 || busy !== 1'b0) begin
      bad++; $display("FAIL abort_no_done: got done=%0d busy=%b want 0/0", done_a, busy);
    end
    in_valid = 1'b0;
    clear_stats();
    run_a(1'b0, 1'b0, t0, to);
    errs = image_errors();
    total++;
    if (to || done_a !== 1 || errs !== 0) begin
      bad++; $display("FAIL abort_refill: got done=%0d bad_cells=%0d want 1/0", done_a, errs);
    end
  endtask

  task automatic test_start_filter();
    int t0; bit to; int errs;
    clear_stats();
    start = 1'b0; in_valid = 1'b1;
    repeat (20) tick();
    total++;
    if (we_a !== 0 || rdy_idle_a !== 0 || busy_a !== 0) begin
      bad++; $display("FAIL idle_quiet: got we=%0d rdy=%0d busy=%0d want 0/0/0", we_a, rdy_idle_a, busy_a);
    end
    run_a(1'b0, 1'b1, t0, to);
    start = 1'b0;
    repeat (10) tick();
    errs = image_errors();
    total++;
    if (to || done_a !== 1 || we_a !== 4356 || errs !== 0) begin
      bad++; $display("FAIL spam_frame: got done=%0d we=%0d bad_cells=%0d want 1/4356/0", done_a, we_a, errs);
    end
    total++;
    if (done_cyc_a !== t0 + 4358) begin
      bad++; $display("FAIL spam_done_cycle: got %0d want 4358", done_cyc_a - t0);
    end
    total++;
    if (outside_a !== 0 || rdy_idle_a !== 0 || busy !== 1'b0) begin
      bad++; $display("FAIL spam_no_restart: got outside=%0d rdy_idle=%0d busy=%b want 0/0/0",
                      outside_a, rdy_idle_a, busy);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_small_frame();
    int errs = 0;
    tick();
    start_b = 1'b1; in_valid_b = 1'b1; in_pixel_b = hs_b[7:0];
    for (int n = 0; n < 100 && done_b == 0; n++) begin
      tick();
      start_b = 1'b0; in_pixel_b = hs_b[7:0];
    end
    repeat (3) tick();
    total++;
    if (we_b !== 30 || hs_b !== 12) begin
      bad++; $display("FAIL small_counts: got we=%0d hs=%0d want 30/12", we_b, hs_b);
    end
    total++;
    if (last_row_b !== 4 || last_col_b !== 5 || last_data_b !== 0) begin
      bad++; $display("FAIL small_last_write: got (%0d,%0d)=%0d want (4,5)=0", last_row_b, last_col_b, last_data_b);
    end
    total++;
    if (done_b !== 1 || done_cyc_b !== last_we_b + 1) begin
      bad++; $display("FAIL small_done: got count=%0d cycle=%0d want 1 at %0d", done_b, done_cyc_b, last_we_b + 1);
    end
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 6; c++) begin
        logic [7:0] expv;
        if (r == 0 || r == 4 || c == 0 || c == 5) expv = 8'd0;
        else expv = 8'((r - 1) * 4 + (c - 1));
        if (wcnt_b[r][c] != 1 || img_b[r][c] !== expv) errs++;
      end
    total++;
    if (errs !== 0) begin bad++; $display("FAIL small_image: got %0d bad cells want 0", errs); end
    in_valid_b = 1'b0;
  endtask

  initial begin
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 6; c++) wcnt_b[r][c] = 0;
    test_reset();
    test_full_frame();
    test_gaps();
    test_mid_reset();
    test_start_filter();
    test_small_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
